// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus unit: FSM states, grant encoding and
// the byte-offset width helper.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_e;

    // Number of byte-offset bits inside one memory word.
    function automatic int lsb_width(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-way grant between fetch and data requests; on contention the side
// that did not win last time is chosen so neither can starve.
module mem_bus_arbiter
    import mem_bus_pkg::*;
(
    input  logic   if_req_i,
    input  logic   d_req_i,
    input  grant_e last_grant_i,
    output logic   gnt_valid_o,
    output grant_e gnt_o
);

    always_comb begin
        gnt_valid_o = if_req_i | d_req_i;
        gnt_o       = GNT_FETCH;
        if (d_req_i && !(if_req_i && last_grant_i == GNT_DATA)) begin
            gnt_o = GNT_DATA;
        end
    end

endmodule

// File: rtl/mem_bus_unit.sv
// Arbitrated fetch/load-store port onto a single word-addressed memory with
// a request/acknowledge handshake bounded by TIMEOUT cycles.
module mem_bus_unit
    import mem_bus_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IF_REQ,
    input  logic [PC_W-1:0]   IF_ADDR,
    output logic              IF_VALID,
    output logic [DATA_W-1:0] IF_DATA,
    output logic              IF_ERR,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [PC_W-1:0]   D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_VALID,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_ERR,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WRITE_ENABLE,
    output logic [DATA_W-1:0] MEM_STORE,
    input  logic [DATA_W-1:0] MEM_LOAD,
    input  logic              MEM_ACK
);

    localparam int LSB   = lsb_width(DATA_W);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [PC_W-1:0]  ALIGN_MASK = PC_W'((1 << LSB) - 1);

    state_e             state_q, state_d;
    grant_e             last_grant_q, last_grant_d;
    grant_e             grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_store_q, mem_store_d;
    logic               if_valid_q, if_valid_d;
    logic               if_err_q, if_err_d;
    logic               d_valid_q, d_valid_d;
    logic               d_err_q, d_err_d;
    logic [DATA_W-1:0]  if_data_q, if_data_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;

    logic               gnt_valid;
    grant_e             gnt;
    logic [PC_W-1:0]    sel_addr;
    logic               misaligned;

    mem_bus_arbiter u_arb (
        .if_req_i     (IF_REQ),
        .d_req_i      (D_REQ),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_o        (gnt)
    );

    assign sel_addr   = (gnt == GNT_DATA) ? D_ADDR : IF_ADDR;
    assign misaligned = |(sel_addr & ALIGN_MASK);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_store_d  = mem_store_q;
        if_data_d    = if_data_q;
        d_rdata_d    = d_rdata_q;
        if_valid_d   = 1'b0;
        if_err_d     = 1'b0;
        d_valid_d    = 1'b0;
        d_err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (gnt_valid) begin
                    if (misaligned) begin
                        if_err_d = (gnt == GNT_FETCH);
                        d_err_d  = (gnt == GNT_DATA);
                        state_d  = ST_RESP;
                    end else begin
                        mem_req_d    = 1'b1;
                        mem_addr_d   = ADDR_W'(sel_addr >> LSB);
                        mem_we_d     = (gnt == GNT_DATA) ? D_WE : 1'b0;
                        mem_store_d  = (gnt == GNT_DATA) ? D_WDATA : mem_store_q;
                        last_grant_d = gnt;
                        grant_d      = gnt;
                        state_d      = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack on the threshold cycle still counts as success.
                if (MEM_ACK) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (grant_q == GNT_DATA) begin
                        d_valid_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = MEM_LOAD;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_data_d  = MEM_LOAD;
                    end
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if_err_d  = (grant_q == GNT_FETCH);
                    d_err_d   = (grant_q == GNT_DATA);
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_FETCH;
            grant_q      <= GNT_FETCH;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_store_q  <= '0;
            if_valid_q   <= 1'b0;
            if_err_q     <= 1'b0;
            d_valid_q    <= 1'b0;
            d_err_q      <= 1'b0;
            if_data_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_store_q  <= mem_store_d;
            if_valid_q   <= if_valid_d;
            if_err_q     <= if_err_d;
            d_valid_q    <= d_valid_d;
            d_err_q      <= d_err_d;
            if_data_q    <= if_data_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign IF_VALID         = if_valid_q;
    assign IF_ERR           = if_err_q;
    assign IF_DATA          = if_data_q;
    assign D_VALID          = d_valid_q;
    assign D_ERR            = d_err_q;
    assign D_RDATA          = d_rdata_q;
    assign MEM_REQ          = mem_req_q;
    assign MEM_ADDR         = mem_addr_q;
    assign MEM_WRITE_ENABLE = mem_we_q;
    assign MEM_STORE        = mem_store_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed bench for mem_bus_unit: arbitration, alignment errors, timeout
// and reset during an access, with a small reactive memory model.
module tb_mem_bus_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic        IF_VALID;
    logic [31:0] IF_DATA;
    logic        IF_ERR;
    logic        D_REQ;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic        D_VALID;
    logic [31:0] D_RDATA;
    logic        D_ERR;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic        MEM_WRITE_ENABLE;
    logic [31:0] MEM_STORE;
    logic [31:0] MEM_LOAD;
    logic        MEM_ACK;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_ifdata;
    logic [31:0] exp_drdata;

    mem_bus_unit #(.DATA_W(32), .PC_W(32), .ADDR_W(16), .TIMEOUT(15)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .IF_REQ           (IF_REQ),
        .IF_ADDR          (IF_ADDR),
        .IF_VALID         (IF_VALID),
        .IF_DATA          (IF_DATA),
        .IF_ERR           (IF_ERR),
        .D_REQ            (D_REQ),
        .D_WE             (D_WE),
        .D_ADDR           (D_ADDR),
        .D_WDATA          (D_WDATA),
        .D_VALID          (D_VALID),
        .D_RDATA          (D_RDATA),
        .D_ERR            (D_ERR),
        .MEM_REQ          (MEM_REQ),
        .MEM_ADDR         (MEM_ADDR),
        .MEM_WRITE_ENABLE (MEM_WRITE_ENABLE),
        .MEM_STORE        (MEM_STORE),
        .MEM_LOAD         (MEM_LOAD),
        .MEM_ACK          (MEM_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Memory model + observer: acks after ack_delay request cycles (-1 = never),
    // stops at the first response pulse or after 60 cycles.
    task automatic serve(input int ack_delay, input logic [31:0] load_val,
                         output int lat, output int req_hi, output logic [3:0] pulses,
                         output logic [15:0] obs_addr, output logic obs_we,
                         output logic [31:0] obs_store);
        int seen;
        seen = 0; lat = 0; req_hi = 0; pulses = 4'b0;
        obs_addr = '0; obs_we = 1'b0; obs_store = '0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            MEM_ACK = 1'b0;
            pulses = {IF_VALID, IF_ERR, D_VALID, D_ERR};
            if (pulses != 4'b0) begin
                lat = c;
                break;
            end
            if (MEM_REQ) begin
                if (seen == 0) begin
                    obs_addr  = MEM_ADDR;
                    obs_we    = MEM_WRITE_ENABLE;
                    obs_store = MEM_STORE;
                end
                req_hi++;
                seen++;
                if (ack_delay >= 0 && seen == ack_delay + 1) begin
                    MEM_ACK  = 1'b1;
                    MEM_LOAD = load_val;
                end
            end
        end
    endtask

    task automatic release_all();
        IF_REQ  = 1'b0;
        D_REQ   = 1'b0;
        MEM_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        total++; if ({MEM_REQ, MEM_WRITE_ENABLE} !== 2'b00) begin bad++; $display("FAIL reset_ctrl got=%b exp=00", {MEM_REQ, MEM_WRITE_ENABLE}); end
        total++; if ({IF_VALID, IF_ERR, D_VALID, D_ERR} !== 4'b0) begin bad++; $display("FAIL reset_pulses got=%b exp=0000", {IF_VALID, IF_ERR, D_VALID, D_ERR}); end
        total++; if (MEM_ADDR !== 16'h0 || MEM_STORE !== 32'h0) begin bad++; $display("FAIL reset_mem got=%h/%h exp=0/0", MEM_ADDR, MEM_STORE); end
        total++; if (IF_DATA !== 32'h0 || D_RDATA !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0/0", IF_DATA, D_RDATA); end
        RST = 1'b0;
        exp_ifdata = 32'h0;
        exp_drdata = 32'h0;
    endtask

    task automatic test_round_robin();
        int lat, req_hi;
        logic [3:0] p;
        logic [15:0] a;
        logic we;
        logic [31:0] st;
        logic [15:0] exp_addr[4];
        logic [3:0]  exp_p[4];
        exp_addr = '{16'h0080, 16'h0040, 16'h0080, 16'h0040};
        exp_p    = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0100;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h0000_0200; D_WDATA = 32'h0;
        for (int t = 0; t < 4; t++) begin
            serve(0, 32'h1000_0000 + 32'(t), lat, req_hi, p, a, we, st);
            total++; if (a !== exp_addr[t]) begin bad++; $display("FAIL rr_grant%0d got=%h exp=%h", t, a, exp_addr[t]); end
            total++; if (p !== exp_p[t]) begin bad++; $display("FAIL rr_pulse%0d got=%b exp=%b", t, p, exp_p[t]); end
        end
        release_all();
        tick();
        exp_ifdata = 32'h1000_0003;
        exp_drdata = 32'h1000_0002;
        total++; if (IF_DATA !== exp_ifdata || D_RDATA !== exp_drdata) begin bad++; $display("FAIL rr_data got=%h/%h exp=%h/%h", IF_DATA, D_RDATA, exp_ifdata, exp_drdata); end
    endtask

    task automatic test_fetch();
        int lat, req_hi;
        logic [3:0] p;
        logic [15:0] a;
        logic we;
        logic [31:0] st;
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0008;
        serve(1, 32'hDEAD_BEEF, lat, req_hi, p, a, we, st);
        release_all();
        exp_ifdata = 32'hDEAD_BEEF;
        total++; if (a !== 16'h0002 || we !== 1'b0) begin bad++; $display("FAIL fetch_mem got=%h/%b exp=0002/0", a, we); end
        total++; if (p !== 4'b1000 || lat != 3) begin bad++; $display("FAIL fetch_valid got=%b lat=%0d exp=1000 lat=3", p, lat); end
        total++; if (IF_DATA !== exp_ifdata) begin bad++; $display("FAIL fetch_data got=%h exp=%h", IF_DATA, exp_ifdata); end
        tick();
        total++; if (IF_VALID !== 1'b0 || MEM_REQ !== 1'b0) begin bad++; $display("FAIL fetch_one_pulse got=%b/%b exp=0/0", IF_VALID, MEM_REQ); end
    endtask

    task automatic test_store();
        int lat, req_hi;
        logic [3:0] p;
        logic [15:0] a;
        logic we;
        logic [31:0] st;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h0000_0010; D_WDATA = 32'h1234_5678;
        serve(0, 32'hAAAA_5555, lat, req_hi, p, a, we, st);
        release_all();
        total++; if (a !== 16'h0004 || we !== 1'b1 || st !== 32'h1234_5678) begin bad++; $display("FAIL store_mem got=%h/%b/%h exp=0004/1/12345678", a, we, st); end
        total++; if (p !== 4'b0010 || lat != 2) begin bad++; $display("FAIL store_valid got=%b lat=%0d exp=0010 lat=2", p, lat); end
        total++; if (D_RDATA !== exp_drdata) begin bad++; $display("FAIL store_rdata got=%h exp=%h", D_RDATA, exp_drdata); end
        total++; if (MEM_WRITE_ENABLE !== 1'b0) begin bad++; $display("FAIL store_we_drop got=%b exp=0", MEM_WRITE_ENABLE); end
        tick();
    endtask

    task automatic test_load();
        int lat, req_hi;
        logic [3:0] p;
        logic [15:0] a;
        logic we;
        logic [31:0] st;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h0000_0020;
        serve(2, 32'hCAFE_F00D, lat, req_hi, p, a, we, st);
        release_all();
        exp_drdata = 32'hCAFE_F00D;
        total++; if (a !== 16'h0008 || we !== 1'b0) begin bad++; $display("FAIL load_mem got=%h/%b exp=0008/0", a, we); end
        total++; if (p !== 4'b0010 || lat != 4) begin bad++; $display("FAIL load_valid got=%b lat=%0d exp=0010 lat=4", p, lat); end
        total++; if (D_RDATA !== exp_drdata || IF_DATA !== exp_ifdata) begin bad++; $display("FAIL load_data got=%h/%h exp=%h/%h", D_RDATA, IF_DATA, exp_drdata, exp_ifdata); end
        tick();
    endtask

    task automatic test_misaligned();
        int lat, req_hi;
        logic [3:0] p;
        logic [15:0] a;
        logic we;
        logic [31:0] st;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h0000_0006;
        serve(0, 32'h5555_5555, lat, req_hi, p, a, we, st);
        release_all();
        total++; if (p !== 4'b0001 || lat != 1) begin bad++; $display("FAIL mis_d_err got=%b lat=%0d exp=0001 lat=1", p, lat); end
        total++; if (req_hi != 0) begin bad++; $display("FAIL mis_d_noreq got=%0d exp=0", req_hi); end
        total++; if (D_RDATA !== exp_drdata) begin bad++; $display("FAIL mis_d_rdata got=%h exp=%h", D_RDATA, exp_drdata); end
        tick();
        total++; if (D_ERR !== 1'b0) begin bad++; $display("FAIL mis_d_one_pulse got=%b exp=0", D_ERR); end
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0003;
        serve(0, 32'h5555_5555, lat, req_hi, p, a, we, st);
        release_all();
        total++; if (p !== 4'b0100 || lat != 1 || req_hi != 0) begin bad++; $display("FAIL mis_if_err got=%b lat=%0d req=%0d exp=0100 lat=1 req=0", p, lat, req_hi); end
        tick();
    endtask

    task automatic test_stray_ack();
        MEM_ACK = 1'b1; MEM_LOAD = 32'hFFFF_FFFF;
        tick();
        MEM_ACK = 1'b0;
        tick();
        total++; if ({IF_VALID, IF_ERR, D_VALID, D_ERR, MEM_REQ} !== 5'b0) begin bad++; $display("FAIL stray_ack_out got=%b exp=00000", {IF_VALID, IF_ERR, D_VALID, D_ERR, MEM_REQ}); end
        total++; if (IF_DATA !== exp_ifdata || D_RDATA !== exp_drdata) begin bad++; $display("FAIL stray_ack_data got=%h/%h exp=%h/%h", IF_DATA, D_RDATA, exp_ifdata, exp_drdata); end
    endtask

    task automatic test_timeout();
        int lat, req_hi;
        logic [3:0] p;
        logic [15:0] a;
        logic we;
        logic [31:0] st;
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0040;
        serve(-1, 32'h0, lat, req_hi, p, a, we, st);
        release_all();
        total++; if (req_hi != 15) begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=15", req_hi); end
        total++; if (p !== 4'b0100 || lat != 16) begin bad++; $display("FAIL timeout_err got=%b lat=%0d exp=0100 lat=16", p, lat); end
        total++; if (MEM_REQ !== 1'b0 || IF_DATA !== exp_ifdata) begin bad++; $display("FAIL timeout_state got=%b/%h exp=0/%h", MEM_REQ, IF_DATA, exp_ifdata); end
        tick();
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0044;
        serve(0, 32'h0BAD_C0DE, lat, req_hi, p, a, we, st);
        release_all();
        exp_ifdata = 32'h0BAD_C0DE;
        total++; if (p !== 4'b1000 || a !== 16'h0011 || IF_DATA !== exp_ifdata) begin bad++; $display("FAIL timeout_recover got=%b/%h/%h exp=1000/0011/%h", p, a, IF_DATA, exp_ifdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, req_hi;
        logic [3:0] p;
        logic [15:0] a;
        logic we;
        logic [31:0] st;
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0080;
        tick();
        tick();
        total++; if (MEM_REQ !== 1'b1) begin bad++; $display("FAIL rst_mid_inflight got=%b exp=1", MEM_REQ); end
        RST = 1'b1; MEM_ACK = 1'b1; MEM_LOAD = 32'h1111_1111;
        tick();
        RST = 1'b0;
        release_all();
        exp_ifdata = 32'h0;
        exp_drdata = 32'h0;
        total++; if ({MEM_REQ, MEM_WRITE_ENABLE, IF_VALID, IF_ERR, D_VALID, D_ERR} !== 6'b0) begin bad++; $display("FAIL rst_mid_ctrl got=%b exp=000000", {MEM_REQ, MEM_WRITE_ENABLE, IF_VALID, IF_ERR, D_VALID, D_ERR}); end
        total++; if (IF_DATA !== 32'h0 || MEM_ADDR !== 16'h0) begin bad++; $display("FAIL rst_mid_data got=%h/%h exp=0/0", IF_DATA, MEM_ADDR); end
        tick();
        total++; if (IF_VALID !== 1'b0 || IF_ERR !== 1'b0) begin bad++; $display("FAIL rst_mid_no_resp got=%b/%b exp=0/0", IF_VALID, IF_ERR); end
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0100;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h0000_0300;
        serve(0, 32'h7777_7777, lat, req_hi, p, a, we, st);
        release_all();
        total++; if (a !== 16'h00C0 || p !== 4'b0010) begin bad++; $display("FAIL rst_mid_last_grant got=%h/%b exp=00c0/0010", a, p); end
        tick();
    endtask

    initial begin
        RST = 1'b1;
        IF_REQ = 1'b0; IF_ADDR = '0;
        D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0;
        MEM_LOAD = '0; MEM_ACK = 1'b0;
        test_reset();
        test_round_robin();
        test_fetch();
        test_store();
        test_load();
        test_misaligned();
        test_stray_ack();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
